// File: rtl/shared_mul_pkg.sv
// Shared definitions for the two-core shared multiplier: FSM states,
// default operand width and the core-index type.
package shared_mul_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    CORE0 = 1'b0,
    CORE1 = 1'b1
  } core_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier core: one partial product per step,
// unsigned magnitudes in, unsigned 2*WIDTH product out.
module mul_iter
  import shared_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic [2*WIDTH-1:0] prod
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  // Multiplicand walks left while the multiplier is consumed LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, mag_a};
      mplier <= mag_b;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign prod = acc;

endmodule

// File: rtl/shared_mul_arbiter.sv
// Two-core arbiter in front of one iterative multiplier (mult/multu).
// Define SHARED_MUL_RR_EN for round-robin ties; default is fixed priority to core 0.
module shared_mul_arbiter
  import shared_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             sgn0,
  input  logic             sgn1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state;
  state_t             nxt;
  logic [CW-1:0]      cnt;
  core_t              pick;
  core_t              win;
  core_t              last;
  logic               neg_q;
  logic [1:0]         gnt_q;
  logic               done_q;
  logic               arb_go;
  logic               load;
  logic               step;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_sgn;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

`ifdef SHARED_MUL_RR_EN
  always_comb begin
    pick = last;
    if (req0 && req1) begin
      pick = (last == CORE0) ? CORE1 : CORE0;
    end else if (req0) begin
      pick = CORE0;
    end else if (req1) begin
      pick = CORE1;
    end
  end
`else
  // With no requester the pick is a don't-care, so it simply mirrors the pointer.
  always_comb begin
    pick = last;
    if (req0) begin
      pick = CORE0;
    end else if (req1) begin
      pick = CORE1;
    end
  end
`endif

  assign sel_a   = (pick == CORE1) ? a1 : a0;
  assign sel_b   = (pick == CORE1) ? b1 : b0;
  assign sel_sgn = (pick == CORE1) ? sgn1 : sgn0;
  assign mag_a   = (sel_sgn && sel_a[WIDTH-1]) ? -sel_a : sel_a;
  assign mag_b   = (sel_sgn && sel_b[WIDTH-1]) ? -sel_b : sel_b;

  // The done cycle is not an arbitration slot: the finishing core is still
  // dropping its req there, so sampling it would re-grant a stale request.
  assign arb_go = (state == IDLE) && !done_q && (req0 || req1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt  = state;
    load = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: begin
        if (arb_go) begin
          load = 1'b1;
          nxt  = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          nxt = DONE;
        end
      end
      DONE: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      win    <= CORE0;
      neg_q  <= 1'b0;
      gnt_q  <= 2'b00;
      done_q <= 1'b0;
      last   <= CORE1;
      hi     <= '0;
      lo     <= '0;
    end else begin
      gnt_q  <= 2'b00;
      done_q <= 1'b0;
      if (load) begin
        cnt   <= '0;
        win   <= pick;
        neg_q <= sel_sgn && (sel_a[WIDTH-1] ^ sel_b[WIDTH-1]);
        gnt_q <= (pick == CORE1) ? 2'b10 : 2'b01;
      end else if (step) begin
        cnt <= cnt + 1'b1;
      end
      if (state == DONE) begin
        {hi, lo} <= prod_fix;
        done_q   <= 1'b1;
        last     <= win;
      end
    end
  end

  mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .mag_a (mag_a),
    .mag_b (mag_b),
    .prod  (prod)
  );

  assign prod_fix = neg_q ? -prod : prod;

  assign gnt0  = gnt_q[0];
  assign gnt1  = gnt_q[1];
  assign done0 = done_q && (win == CORE0);
  assign done1 = done_q && (win == CORE1);
  assign busy  = (state != IDLE);

endmodule
